caxi4interconnect_slv_transaction_throttle: RTL and testbench

CAXI4INTERCONNECT_SLV_TRANSACTION_THROTTLE -- requirements
Module: caxi4interconnect_SlvTransactionThrottle

---
 rtl/caxi4interconnect_slv_transaction_throttle.sv | 204 ++++++++++++++++++++
 tb/tb_caxi4interconnect_slv_transaction_throttle.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caxi4interconnect_slv_transaction_throttle.sv
// Purpose : caps outstanding AXI4 write/read bursts toward one slave by gating AW/AR valid+ready.
// Latency : zero-cycle combinational gating; counts update on the SLV_CLK edge after a handshake.
// Backpres: when a count reaches its maximum the channel stalls (upXREADY=0, dnXVALID=0) until a
//           B / RLAST completion frees a slot; the slot re-grants one cycle after the completion.
//
// Ports:
//   SLV_CLK, sysReset                 clock, asynchronous active-low reset
//   upAWVALID/upAWREADY               AW handshake, crossbar side
//   dnAWVALID/dnAWREADY               AW handshake, slave side
//   upARVALID/upARREADY/dnARVALID/dnARREADY   AR handshake, same arrangement
//   BVALID/BREADY, RVALID/RREADY/RLAST        response channels, observed only
//   wrCount/rdCount                   outstanding burst counts
//   wrFull/rdFull/idle/protErr        status (protErr sticky until reset)
//
// Optional build macro: CAXI4_SLV_RW_EXCLUSIVE_EN -- when defined, an IDLE/WR/RD arbiter makes
// reads and writes mutually exclusive at the slave; direction changes need a drain to zero plus
// one IDLE cycle. Address payloads never pass through this block.

module caxi4interconnect_slv_transaction_throttle #(
  parameter int MAX_WR_OUTSTANDING = 4,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic       SLV_CLK,
  input  logic       sysReset,
  input  logic       upAWVALID,
  output logic       upAWREADY,
  output logic       dnAWVALID,
  input  logic       dnAWREADY,
  input  logic       upARVALID,
  output logic       upARREADY,
  output logic       dnARVALID,
  input  logic       dnARREADY,
  input  logic       BVALID,
  input  logic       BREADY,
  input  logic       RVALID,
  input  logic       RREADY,
  input  logic       RLAST,
  output logic [3:0] wrCount,
  output logic [3:0] rdCount,
  output logic       wrFull,
  output logic       rdFull,
  output logic       idle,
  output logic       protErr
);

  localparam logic [3:0] WR_MAX = 4'(MAX_WR_OUTSTANDING);
  localparam logic [3:0] RD_MAX = 4'(MAX_RD_OUTSTANDING);

  logic [3:0] wr_count_q, wr_count_d;
  logic [3:0] rd_count_q, rd_count_d;
  logic       prot_err_q, prot_err_d;

  logic wr_full, rd_full;
  logic aw_grant, ar_grant;
  logic aw_hs, ar_hs, b_hs, rd_cmp;

  // Full flags come only from registered counts, so a completion in the
  // same cycle cannot open the gate early.
  assign wr_full = (wr_count_q == WR_MAX);
  assign rd_full = (rd_count_q == RD_MAX);

  // Valid and ready are both qualified by the grant; grants never look at
  // any ready input, which keeps the paths free of combinational loops.
  assign dnAWVALID = upAWVALID & aw_grant;
  assign upAWREADY = dnAWREADY & aw_grant;
  assign dnARVALID = upARVALID & ar_grant;
  assign upARREADY = dnARREADY & ar_grant;

  assign aw_hs  = dnAWVALID & dnAWREADY;
  assign ar_hs  = dnARVALID & dnARREADY;
  assign b_hs   = BVALID & BREADY;
  assign rd_cmp = RVALID & RREADY & RLAST;

  // Outstanding counters. A simultaneous issue and completion cancel out.
  // A completion with nothing outstanding saturates at zero and is flagged.
  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    prot_err_d = prot_err_q;

    if (aw_hs && !b_hs) begin
      wr_count_d = wr_count_q + 4'd1;
    end else if (b_hs && !aw_hs && (wr_count_q != 4'd0)) begin
      wr_count_d = wr_count_q - 4'd1;
    end

    if (ar_hs && !rd_cmp) begin
      rd_count_d = rd_count_q + 4'd1;
    end else if (rd_cmp && !ar_hs && (rd_count_q != 4'd0)) begin
      rd_count_d = rd_count_q - 4'd1;
    end

    if ((b_hs && (wr_count_q == 4'd0)) || (rd_cmp && (rd_count_q == 4'd0))) begin
      prot_err_d = 1'b1;
    end
  end

  always_ff @(posedge SLV_CLK or negedge sysReset) begin
    if (!sysReset) begin
      wr_count_q <= 4'd0;
      rd_count_q <= 4'd0;
      prot_err_q <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      prot_err_q <= prot_err_d;
    end
  end

`ifdef CAXI4_SLV_RW_EXCLUSIVE_EN

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;

  // Grant decode. In IDLE a lone requester wins; under contention the side
  // that did not win last time goes first. The full check in IDLE is only a
  // guard: counts are always zero there.
  always_comb begin
    aw_grant = 1'b0;
    ar_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (upAWVALID && (!upARVALID || (last_grant_q == GRANT_READ))) begin
          aw_grant = !wr_full;
        end else if (upARVALID) begin
          ar_grant = !rd_full;
        end
      end
      ST_WR:   aw_grant = !wr_full;
      ST_RD:   ar_grant = !rd_full;
      default: begin
        aw_grant = 1'b0;
        ar_grant = 1'b0;
      end
    endcase
  end

  // Direction ownership: leave WR/RD only once the owning count drains to
  // zero, so the opposite direction always sees at least one IDLE cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          state_d      = ST_WR;
          last_grant_d = GRANT_WRITE;
        end else if (ar_hs) begin
          state_d      = ST_RD;
          last_grant_d = GRANT_READ;
        end
      end
      ST_WR: begin
        if (wr_count_d == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (rd_count_d == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SLV_CLK or negedge sysReset) begin
    if (!sysReset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign idle = (wr_count_q == 4'd0) && (rd_count_q == 4'd0) && (state_q == ST_IDLE);

`else

  // Independent channels: each is throttled only by its own count.
  assign aw_grant = !wr_full;
  assign ar_grant = !rd_full;

  assign idle = (wr_count_q == 4'd0) && (rd_count_q == 4'd0);

`endif

  assign wrCount = wr_count_q;
  assign rdCount = rd_count_q;
  assign wrFull  = wr_full;
  assign rdFull  = rd_full;
  assign protErr = prot_err_q;

endmodule

// File: tb/tb_caxi4interconnect_slv_transaction_throttle.sv
module tb_caxi4interconnect_slv_transaction_throttle;

  localparam int MAXW = 4;
  localparam int MAXR = 4;

  logic       SLV_CLK = 1'b0;
  logic       sysReset;
  logic       upAWVALID, dnAWREADY, upARVALID, dnARREADY;
  logic       BVALID, BREADY, RVALID, RREADY, RLAST;
  logic       upAWREADY, dnAWVALID, upARREADY, dnARVALID;
  logic [3:0] wrCount, rdCount;
  logic       wrFull, rdFull, idle, protErr;

  caxi4interconnect_slv_transaction_throttle #(
    .MAX_WR_OUTSTANDING(MAXW),
    .MAX_RD_OUTSTANDING(MAXR)
  ) dut (
    .SLV_CLK   (SLV_CLK),
    .sysReset  (sysReset),
    .upAWVALID (upAWVALID),
    .upAWREADY (upAWREADY),
    .dnAWVALID (dnAWVALID),
    .dnAWREADY (dnAWREADY),
    .upARVALID (upARVALID),
    .upARREADY (upARREADY),
    .dnARVALID (dnARVALID),
    .dnARREADY (dnARREADY),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .RLAST     (RLAST),
    .wrCount   (wrCount),
    .rdCount   (rdCount),
    .wrFull    (wrFull),
    .rdFull    (rdFull),
    .idle      (idle),
    .protErr   (protErr)
  );

  always #5 SLV_CLK = ~SLV_CLK;

  int checks   = 0;
  int failures = 0;

  // Observed vector: {upAWREADY,dnAWVALID,upARREADY,dnARVALID,wrFull,rdFull,idle,protErr,wrCount,rdCount}
  function automatic logic [15:0] outs();
    return {upAWREADY, dnAWVALID, upARREADY, dnARVALID, wrFull, rdFull, idle, protErr,
            wrCount, rdCount};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic apply(input logic aw, input logic awr, input logic ar, input logic arr,
                       input logic b, input logic r, input logic rl);
    upAWVALID = aw;  dnAWREADY = awr;
    upARVALID = ar;  dnARREADY = arr;
    BVALID    = b;   BREADY    = b;
    RVALID    = r;   RREADY    = r;
    RLAST     = rl;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    sysReset = 1'b0;
    @(negedge SLV_CLK);
    @(negedge SLV_CLK);
    sysReset = 1'b1;
    @(posedge SLV_CLK);
    #1;
  endtask

  // ---------------- reference model (plain counts and a mode number) ----------------
  int m_wr, m_rd, m_mode;   // m_mode: 0 none, 1 writes own slave, 2 reads own slave
  bit m_prot, m_last_wr, m_ag, m_rg;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_mode = 0; m_prot = 0; m_last_wr = 0;
  endtask

  function automatic logic [15:0] model_expect();
    bit model_idle;
`ifdef CAXI4_SLV_RW_EXCLUSIVE_EN
    m_ag = 0; m_rg = 0;
    if (m_mode == 1) m_ag = (m_wr < MAXW);
    else if (m_mode == 2) m_rg = (m_rd < MAXR);
    else if (upAWVALID && upARVALID) begin
      if (m_last_wr) m_rg = 1; else m_ag = 1;
    end else if (upAWVALID) m_ag = 1;
    else if (upARVALID) m_rg = 1;
    model_idle = (m_wr == 0) && (m_rd == 0) && (m_mode == 0);
`else
    m_ag = (m_wr < MAXW);
    m_rg = (m_rd < MAXR);
    model_idle = (m_wr == 0) && (m_rd == 0);
`endif
    return {dnAWREADY & m_ag, upAWVALID & m_ag, dnARREADY & m_rg, upARVALID & m_rg,
            m_wr == MAXW, m_rd == MAXR, model_idle, m_prot, 4'(m_wr), 4'(m_rd)};
  endfunction

  task automatic model_step();
    int aw_n, ar_n, b_n, c_n;
    aw_n = (upAWVALID && m_ag && dnAWREADY) ? 1 : 0;
    ar_n = (upARVALID && m_rg && dnARREADY) ? 1 : 0;
    b_n  = (BVALID && BREADY) ? 1 : 0;
    c_n  = (RVALID && RREADY && RLAST) ? 1 : 0;
    if ((b_n == 1 && m_wr == 0) || (c_n == 1 && m_rd == 0)) m_prot = 1;
    m_wr = m_wr + aw_n - b_n; if (m_wr < 0) m_wr = 0;
    m_rd = m_rd + ar_n - c_n; if (m_rd < 0) m_rd = 0;
    if (m_mode == 0) begin
      if (aw_n == 1) begin m_mode = 1; m_last_wr = 1; end
      else if (ar_n == 1) begin m_mode = 2; m_last_wr = 0; end
    end else if (m_mode == 1 && m_wr == 0) m_mode = 0;
    else if (m_mode == 2 && m_rd == 0) m_mode = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       aw, awr, ar, arr, b, r, rl;
    logic [7:0] flags;   // {upAWREADY,dnAWVALID,upARREADY,dnARVALID,wrFull,rdFull,idle,protErr}
    logic [3:0] wr, rd;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic aw, input logic awr, input logic ar, input logic arr,
                              input logic b, input logic r, input logic rl,
                              input logic [7:0] flags, input logic [3:0] wr, input logic [3:0] rd);
    vec_t v;
    v.aw = aw; v.awr = awr; v.ar = ar; v.arr = arr; v.b = b; v.r = r; v.rl = rl;
    v.flags = flags; v.wr = wr; v.rd = rd;
    return v;
  endfunction

  initial begin
    // Write burst flood against the default limit, then drain with B responses.
    vecs[0]  = mk(1,1,0,0, 0,0,0, 8'b1100_0010, 4'd0, 4'd0);
    vecs[1]  = mk(1,1,0,0, 0,0,0, 8'b1100_0000, 4'd1, 4'd0);
    vecs[2]  = mk(1,1,0,0, 0,0,0, 8'b1100_0000, 4'd2, 4'd0);
    vecs[3]  = mk(1,1,0,0, 0,0,0, 8'b1100_0000, 4'd3, 4'd0);
    vecs[4]  = mk(1,1,0,0, 1,0,0, 8'b0000_1000, 4'd4, 4'd0); // full: AW blocked despite B
    vecs[5]  = mk(1,1,0,0, 0,0,0, 8'b1100_0000, 4'd3, 4'd0); // 5th AW accepted
    vecs[6]  = mk(0,0,0,0, 1,0,0, 8'b0000_1000, 4'd4, 4'd0);
    vecs[7]  = mk(1,1,0,0, 1,0,0, 8'b1100_0000, 4'd3, 4'd0); // AW+B cancel
    vecs[8]  = mk(0,0,0,0, 1,0,0, 8'b0000_0000, 4'd3, 4'd0);
    vecs[9]  = mk(1,1,0,0, 1,0,0, 8'b1100_0000, 4'd2, 4'd0); // count 2 holds
    vecs[10] = mk(0,0,0,0, 1,0,0, 8'b0000_0000, 4'd2, 4'd0);
    vecs[11] = mk(0,0,0,0, 1,0,0, 8'b0000_0000, 4'd1, 4'd0);
    vecs[12] = mk(0,0,0,0, 0,0,0, 8'b0000_0010, 4'd0, 4'd0);
    // Read side: non-last beats do not complete; RLAST does.
    vecs[13] = mk(0,0,1,1, 0,0,0, 8'b0011_0010, 4'd0, 4'd0);
    vecs[14] = mk(0,0,1,1, 0,1,0, 8'b0011_0000, 4'd0, 4'd1);
    vecs[15] = mk(0,0,1,1, 0,1,1, 8'b0011_0000, 4'd0, 4'd2);
    vecs[16] = mk(0,0,1,1, 0,0,0, 8'b0011_0000, 4'd0, 4'd2);
    vecs[17] = mk(0,0,1,1, 0,0,0, 8'b0011_0000, 4'd0, 4'd3);
    vecs[18] = mk(0,0,1,1, 0,1,1, 8'b0000_0100, 4'd0, 4'd4);
    vecs[19] = mk(0,0,0,0, 0,1,1, 8'b0000_0000, 4'd0, 4'd3);
    vecs[20] = mk(0,0,0,0, 0,1,1, 8'b0000_0000, 4'd0, 4'd2);
    vecs[21] = mk(0,0,0,0, 0,1,1, 8'b0000_0000, 4'd0, 4'd1);
    vecs[22] = mk(0,0,0,0, 0,1,1, 8'b0000_0010, 4'd0, 4'd0); // completion with nothing outstanding
    vecs[23] = mk(0,0,0,0, 0,0,0, 8'b0000_0011, 4'd0, 4'd0);

    // Reset state while reset is held.
    apply(0, 0, 0, 0, 0, 0, 0);
    sysReset = 1'b0;
    #2;
    check("reset_state", outs(), {8'b0000_0010, 4'd0, 4'd0});
    @(negedge SLV_CLK);
    sysReset = 1'b1;
    @(posedge SLV_CLK);
    #1;

    for (int i = 0; i < 24; i++) begin
      apply(vecs[i].aw, vecs[i].awr, vecs[i].ar, vecs[i].arr, vecs[i].b, vecs[i].r, vecs[i].rl);
      @(negedge SLV_CLK);
      check($sformatf("vec%0d", i), outs(), {vecs[i].flags, vecs[i].wr, vecs[i].rd});
      @(posedge SLV_CLK);
      #1;
    end

    // protErr is sticky through idle cycles.
    apply(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge SLV_CLK);
      check($sformatf("prot_sticky%0d", i), {15'd0, protErr}, 16'd1);
      @(posedge SLV_CLK);
      #1;
    end

    // Mid-burst asynchronous reset drops counts before the next edge.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 1, 0, 0, 0);
      @(posedge SLV_CLK);
      #1;
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    check("rd_before_reset", {12'd0, rdCount}, 16'd3);
    #2;
    sysReset = 1'b0;
    #1;
    check("async_reset", {idle, protErr, 6'd0, wrCount, rdCount}, 16'h8000);
    @(negedge SLV_CLK);
    sysReset = 1'b1;
    @(posedge SLV_CLK);
    #1;
    apply(0, 0, 0, 0, 0, 1, 1);   // stale completion after reset
    @(posedge SLV_CLK);
    #1;
    apply(0, 0, 0, 0, 0, 0, 0);
    @(negedge SLV_CLK);
    check("stale_completion", {protErr, 7'd0, rdCount, wrCount}, 16'h8000);
    @(posedge SLV_CLK);
    #1;

    // Contention between AW and AR held from reset.
    do_reset();
`ifdef CAXI4_SLV_RW_EXCLUSIVE_EN
    apply(1, 1, 1, 1, 0, 0, 0);
    @(negedge SLV_CLK);
    check("excl_c0_aw_first", outs(), {8'b1100_0010, 4'd0, 4'd0});
    @(posedge SLV_CLK); #1;
    apply(0, 1, 1, 1, 1, 0, 0);
    @(negedge SLV_CLK);
    check("excl_c1_ar_blocked", outs(), {8'b1000_0000, 4'd1, 4'd0});
    @(posedge SLV_CLK); #1;
    apply(0, 1, 1, 1, 0, 0, 0);
    @(negedge SLV_CLK);
    check("excl_c2_ar_after_idle", outs(), {8'b0011_0010, 4'd0, 4'd0});
    @(posedge SLV_CLK); #1;
    apply(1, 1, 0, 1, 0, 1, 1);
    @(negedge SLV_CLK);
    check("excl_c3_aw_blocked", outs(), {8'b0010_0000, 4'd0, 4'd1});
    @(posedge SLV_CLK); #1;
    apply(1, 1, 1, 1, 0, 0, 0);
    @(negedge SLV_CLK);
    check("excl_c4_write_wins", outs(), {8'b1100_0010, 4'd0, 4'd0});
    @(posedge SLV_CLK); #1;
`else
    apply(1, 1, 1, 1, 0, 0, 0);
    @(negedge SLV_CLK);
    check("both_first_cycle", outs(), {8'b1111_0010, 4'd0, 4'd0});
    @(posedge SLV_CLK); #1;
    apply(0, 0, 0, 0, 0, 0, 0);
    @(negedge SLV_CLK);
    check("both_counted", {8'd0, wrCount, rdCount}, {8'd0, 4'd1, 4'd1});
    @(posedge SLV_CLK); #1;
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      upAWVALID = 1'($urandom_range(0, 1));
      dnAWREADY = ($urandom_range(0, 3) != 0);
      upARVALID = 1'($urandom_range(0, 1));
      dnARREADY = ($urandom_range(0, 3) != 0);
      BVALID    = ($urandom_range(0, 2) == 0);
      BREADY    = ($urandom_range(0, 3) != 0);
      RVALID    = ($urandom_range(0, 2) == 0);
      RREADY    = ($urandom_range(0, 3) != 0);
      RLAST     = 1'($urandom_range(0, 1));
      @(negedge SLV_CLK);
      check($sformatf("rand%0d", i), outs(), model_expect());
      model_step();
      @(posedge SLV_CLK);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
